// File: rtl/rollback_arbiter.sv
// rtl/rollback_arbiter.sv - per-thread rollback collection, round-robin issue and squash windows
module rollback_arbiter #(
    parameter int THREADS       = 4,
    parameter int SQUASH_CYCLES = 5,
    parameter int ADDR_WIDTH    = 32,
    localparam int TIDW         = $clog2(THREADS),
    localparam int CW           = $clog2(SQUASH_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sx_rollback_req,
    input  logic [TIDW-1:0]       sx_thread_idx,
    input  logic [ADDR_WIDTH-1:0] sx_rollback_pc,
    input  logic                  dm_rollback_req,
    input  logic [TIDW-1:0]       dm_thread_idx,
    input  logic [ADDR_WIDTH-1:0] dm_rollback_pc,
    input  logic                  mx_rollback_req,
    input  logic [TIDW-1:0]       mx_thread_idx,
    input  logic [ADDR_WIDTH-1:0] mx_rollback_pc,
    output logic                  wb_rollback_en,
    output logic [TIDW-1:0]       wb_rollback_thread_idx,
    output logic [1:0]            wb_rollback_pipeline,
    output logic [ADDR_WIDTH-1:0] wb_rollback_pc,
    output logic [THREADS-1:0]    wb_squash_mask,
    output logic                  wb_rollback_dropped
);
    localparam logic [1:0] PIPE_MEM    = 2'd0;
    localparam logic [1:0] PIPE_SCYCLE = 2'd1;
    localparam logic [1:0] PIPE_MCYCLE = 2'd2;

    // Deeper stage holds the older instruction, so it ranks higher.
    function automatic logic [1:0] rank(input logic [1:0] pipe);
        case (pipe)
            PIPE_MCYCLE: rank = 2'd2;
            PIPE_MEM:    rank = 2'd1;
            default:     rank = 2'd0;
        endcase
    endfunction

    logic [THREADS-1:0]    slot_valid_q, slot_valid_d;
    logic [1:0]            slot_pipe_q [THREADS];
    logic [1:0]            slot_pipe_d [THREADS];
    logic [ADDR_WIDTH-1:0] slot_pc_q   [THREADS];
    logic [ADDR_WIDTH-1:0] slot_pc_d   [THREADS];
    logic [CW-1:0]         squash_cnt_q [THREADS];
    logic [CW-1:0]         squash_cnt_d [THREADS];
    logic [TIDW-1:0]       ptr_q, ptr_d;
    logic                  en_q, en_d;
    logic [TIDW-1:0]       tid_q, tid_d;
    logic [1:0]            pipe_q, pipe_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  dropped_q, dropped_d;

    logic                  grant_valid;
    logic [TIDW-1:0]       grant_idx;
    logic [TIDW:0]         search_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int i = 0; i < THREADS; i++) begin
            search_idx = {1'b0, ptr_q} + (TIDW+1)'(i);
            if (search_idx >= (TIDW+1)'(THREADS))
                search_idx = search_idx - (TIDW+1)'(THREADS);
            if (!grant_valid && slot_valid_q[search_idx[TIDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx[TIDW-1:0];
            end
        end
    end

    logic                  has_sx, has_dm, has_mx, win_valid, blocked, granted;
    logic [1:0]            win_pipe;
    logic [ADDR_WIDTH-1:0] win_pc;

    always_comb begin
        dropped_d = 1'b0;
        has_sx = 1'b0; has_dm = 1'b0; has_mx = 1'b0;
        win_valid = 1'b0; blocked = 1'b0; granted = 1'b0;
        win_pipe = PIPE_MEM; win_pc = '0;
        for (int t = 0; t < THREADS; t++) begin
            slot_valid_d[t] = slot_valid_q[t];
            slot_pipe_d[t]  = slot_pipe_q[t];
            slot_pc_d[t]    = slot_pc_q[t];
            has_sx  = sx_rollback_req && (sx_thread_idx == TIDW'(t));
            has_dm  = dm_rollback_req && (dm_thread_idx == TIDW'(t));
            has_mx  = mx_rollback_req && (mx_thread_idx == TIDW'(t));
            granted = grant_valid && (grant_idx == TIDW'(t));
            blocked = (squash_cnt_q[t] != '0) || granted;
            win_valid = has_sx || has_dm || has_mx;
            if (has_mx) begin
                win_pipe = PIPE_MCYCLE; win_pc = mx_rollback_pc;
            end else if (has_dm) begin
                win_pipe = PIPE_MEM;    win_pc = dm_rollback_pc;
            end else begin
                win_pipe = PIPE_SCYCLE; win_pc = sx_rollback_pc;
            end
            // Same-thread losers are always discarded.
            if ((has_mx && (has_dm || has_sx)) || (has_dm && has_sx))
                dropped_d = 1'b1;
            if (granted)
                slot_valid_d[t] = 1'b0;
            if (win_valid) begin
                if (blocked) begin
                    dropped_d = 1'b1;
                end else if (!slot_valid_q[t]) begin
                    slot_valid_d[t] = 1'b1;
                    slot_pipe_d[t]  = win_pipe;
                    slot_pc_d[t]    = win_pc;
                end else if (rank(win_pipe) > rank(slot_pipe_q[t])) begin
                    slot_pipe_d[t]  = win_pipe;
                    slot_pc_d[t]    = win_pc;
                    dropped_d       = 1'b1;
                end else begin
                    dropped_d = 1'b1;
                end
            end
            if (granted)
                squash_cnt_d[t] = CW'(SQUASH_CYCLES);
            else if (squash_cnt_q[t] != '0)
                squash_cnt_d[t] = squash_cnt_q[t] - 1'b1;
            else
                squash_cnt_d[t] = '0;
        end
    end

    always_comb begin
        en_d   = grant_valid;
        tid_d  = tid_q;
        pipe_d = pipe_q;
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        if (grant_valid) begin
            tid_d  = grant_idx;
            pipe_d = slot_pipe_q[grant_idx];
            pc_d   = slot_pc_q[grant_idx];
            ptr_d  = (grant_idx == TIDW'(THREADS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid_q <= '0;
            for (int t = 0; t < THREADS; t++) begin
                slot_pipe_q[t]  <= '0;
                slot_pc_q[t]    <= '0;
                squash_cnt_q[t] <= '0;
            end
            ptr_q     <= '0;
            en_q      <= 1'b0;
            tid_q     <= '0;
            pipe_q    <= '0;
            pc_q      <= '0;
            dropped_q <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int t = 0; t < THREADS; t++) begin
                slot_pipe_q[t]  <= slot_pipe_d[t];
                slot_pc_q[t]    <= slot_pc_d[t];
                squash_cnt_q[t] <= squash_cnt_d[t];
            end
            ptr_q     <= ptr_d;
            en_q      <= en_d;
            tid_q     <= tid_d;
            pipe_q    <= pipe_d;
            pc_q      <= pc_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        for (int t = 0; t < THREADS; t++)
            wb_squash_mask[t] = (squash_cnt_q[t] != '0);
    end

    assign wb_rollback_en         = en_q;
    assign wb_rollback_thread_idx = tid_q;
    assign wb_rollback_pipeline   = pipe_q;
    assign wb_rollback_pc         = pc_q;
    assign wb_rollback_dropped    = dropped_q;
endmodule

// File: tb/tb_rollback_arbiter.sv
// tb/tb_rollback_arbiter.sv - directed self-checking bench for rollback_arbiter
module tb_rollback_arbiter;
    localparam logic [1:0] PIPE_MEM    = 2'd0;
    localparam logic [1:0] PIPE_SCYCLE = 2'd1;
    localparam logic [1:0] PIPE_MCYCLE = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sx_rollback_req = 1'b0, dm_rollback_req = 1'b0, mx_rollback_req = 1'b0;
    logic [1:0]  sx_thread_idx = '0, dm_thread_idx = '0, mx_thread_idx = '0;
    logic [31:0] sx_rollback_pc = '0, dm_rollback_pc = '0, mx_rollback_pc = '0;
    logic        wb_rollback_en;
    logic [1:0]  wb_rollback_thread_idx;
    logic [1:0]  wb_rollback_pipeline;
    logic [31:0] wb_rollback_pc;
    logic [3:0]  wb_squash_mask;
    logic        wb_rollback_dropped;

    int errors = 0;
    int checks = 0;

    rollback_arbiter #(.THREADS(4), .SQUASH_CYCLES(5), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .sx_rollback_req(sx_rollback_req), .sx_thread_idx(sx_thread_idx), .sx_rollback_pc(sx_rollback_pc),
        .dm_rollback_req(dm_rollback_req), .dm_thread_idx(dm_thread_idx), .dm_rollback_pc(dm_rollback_pc),
        .mx_rollback_req(mx_rollback_req), .mx_thread_idx(mx_thread_idx), .mx_rollback_pc(mx_rollback_pc),
        .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .wb_rollback_pipeline(wb_rollback_pipeline), .wb_rollback_pc(wb_rollback_pc),
        .wb_squash_mask(wb_squash_mask), .wb_rollback_dropped(wb_rollback_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        sx_rollback_req = 1'b0;
        dm_rollback_req = 1'b0;
        mx_rollback_req = 1'b0;
    endtask

    task automatic req_sx(input logic [1:0] t, input logic [31:0] pc);
        sx_rollback_req = 1'b1; sx_thread_idx = t; sx_rollback_pc = pc;
    endtask
    task automatic req_dm(input logic [1:0] t, input logic [31:0] pc);
        dm_rollback_req = 1'b1; dm_thread_idx = t; dm_rollback_pc = pc;
    endtask
    task automatic req_mx(input logic [1:0] t, input logic [31:0] pc);
        mx_rollback_req = 1'b1; mx_thread_idx = t; mx_rollback_pc = pc;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_issue(input string tag, input logic [1:0] t, input logic [1:0] p,
                               input logic [31:0] pc);
        check({tag, "_en"}, 64'(wb_rollback_en), 64'd1);
        check({tag, "_tid"}, 64'(wb_rollback_thread_idx), 64'(t));
        check({tag, "_pipe"}, 64'(wb_rollback_pipeline), 64'(p));
        check({tag, "_pc"}, 64'(wb_rollback_pc), 64'(pc));
    endtask

    initial begin
        tick();
        tick();
        check("rst_en", 64'(wb_rollback_en), 64'd0);
        check("rst_tid", 64'(wb_rollback_thread_idx), 64'd0);
        check("rst_pc", 64'(wb_rollback_pc), 64'd0);
        check("rst_mask", 64'(wb_squash_mask), 64'd0);
        check("rst_drop", 64'(wb_rollback_dropped), 64'd0);
        reset = 1'b1;
        tick();

        // 1: single dm request and the squash window that follows
        req_dm(2'd2, 32'h1000);
        tick(); clear_reqs();
        check("t1_c1_en", 64'(wb_rollback_en), 64'd0);
        tick();
        check_issue("t1", 2'd2, PIPE_MEM, 32'h1000);
        check("t1_mask_c2", 64'(wb_squash_mask), 64'b0100);
        for (int c = 3; c <= 6; c++) begin
            tick();
            check($sformatf("t1_mask_c%0d", c), 64'(wb_squash_mask), 64'b0100);
        end
        tick();
        check("t1_mask_c7", 64'(wb_squash_mask), 64'd0);
        check("t1_c7_en", 64'(wb_rollback_en), 64'd0);

        // 2: three same-thread requests, mx wins
        req_sx(2'd1, 32'h10); req_dm(2'd1, 32'h20); req_mx(2'd1, 32'h30);
        tick(); clear_reqs();
        check("t2_drop", 64'(wb_rollback_dropped), 64'd1);
        tick();
        check_issue("t2", 2'd1, PIPE_MCYCLE, 32'h30);
        check("t2_drop_c2", 64'(wb_rollback_dropped), 64'd0);
        tick();
        check("t2_single", 64'(wb_rollback_en), 64'd0);
        idle(6);

        // 3: round-robin order with wrap back to pointer 0
        apply_reset();
        tick();
        req_dm(2'd0, 32'h700); req_sx(2'd3, 32'h730);
        tick(); clear_reqs();
        tick();
        check_issue("t3a", 2'd0, PIPE_MEM, 32'h700);
        tick();
        check_issue("t3b", 2'd3, PIPE_SCYCLE, 32'h730);
        idle(6);
        req_sx(2'd1, 32'h741); req_dm(2'd0, 32'h740);
        tick(); clear_reqs();
        tick();
        check_issue("t3_wrap", 2'd0, PIPE_MEM, 32'h740);
        tick();
        check_issue("t3_next", 2'd1, PIPE_SCYCLE, 32'h741);
        idle(6);

        // 4: requests inside the squash window are dropped
        req_sx(2'd1, 32'h100);
        tick(); clear_reqs();
        tick();
        check_issue("t4", 2'd1, PIPE_SCYCLE, 32'h100);
        for (int c = 3; c <= 6; c++) begin
            tick();
            req_sx(2'd1, 32'h200 + 32'(c));
            check($sformatf("t4_en_c%0d", c), 64'(wb_rollback_en), 64'd0);
            if (c >= 4)
                check($sformatf("t4_drop_c%0d", c), 64'(wb_rollback_dropped), 64'd1);
        end
        tick();
        req_sx(2'd1, 32'h300);
        check("t4_drop_c7", 64'(wb_rollback_dropped), 64'd1);
        check("t4_mask_c7", 64'(wb_squash_mask[1]), 64'd0);
        tick(); clear_reqs();
        check("t4_drop_c8", 64'(wb_rollback_dropped), 64'd0);
        check("t4_en_c8", 64'(wb_rollback_en), 64'd0);
        tick();
        check_issue("t4_c9", 2'd1, PIPE_SCYCLE, 32'h300);
        idle(6);

        // 5: pending sx slot is upgraded by a later dm request
        apply_reset();
        tick();
        req_dm(2'd0, 32'h500); req_mx(2'd1, 32'h510); req_sx(2'd2, 32'h40);
        tick(); clear_reqs();
        req_dm(2'd2, 32'h50);
        check("t5_c1_en", 64'(wb_rollback_en), 64'd0);
        tick(); clear_reqs();
        check_issue("t5a", 2'd0, PIPE_MEM, 32'h500);
        tick();
        check_issue("t5b", 2'd1, PIPE_MCYCLE, 32'h510);
        tick();
        check_issue("t5c", 2'd2, PIPE_MEM, 32'h50);
        idle(8);
        check("t5_hold_en", 64'(wb_rollback_en), 64'd0);
        check("t5_hold_pc", 64'(wb_rollback_pc), 64'h50);
        check("t5_hold_tid", 64'(wb_rollback_thread_idx), 64'd2);

        // 6: asynchronous reset with pending slots
        req_mx(2'd0, 32'h600); req_dm(2'd1, 32'h610); req_sx(2'd3, 32'h630);
        tick(); clear_reqs();
        #1 reset = 1'b0;
        #1;
        check("t6_en", 64'(wb_rollback_en), 64'd0);
        check("t6_tid", 64'(wb_rollback_thread_idx), 64'd0);
        check("t6_pipe", 64'(wb_rollback_pipeline), 64'd0);
        check("t6_pc", 64'(wb_rollback_pc), 64'd0);
        check("t6_mask", 64'(wb_squash_mask), 64'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("t6_post_en%0d", c), 64'(wb_rollback_en), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
